mem_byte_arbiter: RTL and testbench
===================================

# mem_byte_arbiter

Parametrised successor to the single-port byte-serial memory controller. It arbitrates an instruction-fetch channel and a load/store data channel onto one 8-bit synchronous RAM/IO port, with configurable data width and access size. It adds valid/ready handshakes, an anti-starvation rule, flush that spares committed stores, and optional load sign extension. It sits between the instruction queue / store-load buffer and the top-level RAM port.

## Interface
- ADDR_W, 32, address width
- XLEN, 32, data width; multiple of 8, max 64
- IF_BYTES, 4, bytes per instruction fetch (≤ XLEN/8)
- IO_BASE, 32'h30000, first IO address; IO window is IO_BASE..IO_BASE+7
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low freezes all state
- io_buffer_full  in  1  UART buffer full
- mem_dout  in  8  RAM read byte, valid the cycle after its address is driven
- mem_din  out  8  RAM write byte
- mem_a  out  ADDR_W  RAM byte address
- mem_wr  out  1  1 = write, 0 = read
- flush  in  1  misprediction clear
- if_valid / if_ready  in / out  1  fetch request handshake
- if_addr  in  ADDR_W  fetch address
- if_resp_valid  out  1  one-cycle fetch-done pulse
- if_resp_data  out  XLEN  fetched word, zero-extended
- d_valid / d_ready  in / out  1  data request handshake
- d_we  in  1  1 = store
- d_size  in  2  log2(bytes); values above log2(XLEN/8) clamp to XLEN/8
- d_signed  in  1  sign-extend load result
- d_addr  in  ADDR_W  data address
- d_wdata  in  XLEN  store data
- d_resp_valid  out  1  one-cycle load-data / store-done pulse
- d_resp_data  out  XLEN  load result; 0 for stores

## Operation
- FSM states: IDLE, IF_RD, D_RD, D_WR, DRAIN.
- if_ready = d_ready = (state==IDLE) && rdy && !rst. A request is accepted on a clock edge where valid&&ready.
- Arbitration in IDLE:
  - Data wins.
  - Exception: if the last grant was data and if_valid is high, fetch wins.
  - Only one request is accepted per edge; the loser waits.
- Accepted request latches addr, byte count N = 1<<size (IF_BYTES for fetch), wdata, signed flag. Byte counter cnt starts at 0.
- IF_RD / D_RD:
  - Drive mem_a = addr+cnt, mem_wr=0; cnt++ each cycle.
  - mem_dout is captured into byte lane cnt-1 on the following edge, little-endian.
  - After byte N-1 is addressed, go to DRAIN for the final capture.
  - Then pulse resp_valid and return to IDLE.
- D_WR:
  - Drive mem_a = addr+cnt, mem_din = wdata[8*cnt+7:8*cnt], mem_wr=1.
  - After byte N-1, pulse d_resp_valid and return to IDLE.
- IO stall: in D_WR with current address in the IO window and (io_buffer_full or io_buffer_full delayed one cycle) high:
  - Drive mem_wr=0, mem_a=0, and hold cnt.
- Idle outputs: mem_a=0, mem_wr=0, mem_din=0.
- Flush:
  - IF_RD, D_RD and DRAIN abort to IDLE with no response pulse.
  - D_WR always completes and pulses d_resp_valid.
  - Requests presented during flush are not accepted.
  - Flush takes priority over the last-grant bookkeeping, which resets to "fetch".
- Address arithmetic wraps modulo 2^ADDR_W.
- Reset: state IDLE, all registered outputs 0, last-grant = fetch, result registers 0.

## Timing
- Accept at edge E0.
- Load/fetch of N bytes:
  - Addresses appear in cycles 1..N.
  - Bytes are captured at edges E2..E(N+1).
  - resp_valid is high in cycle N+2 for exactly one cycle.
  - Latency from accept to resp_valid is N+2 cycles.
- Store of N bytes: writes in cycles 1..N, d_resp_valid high in cycle N+1, plus one cycle per IO stall cycle.
- Next accept is possible at the edge ending the resp_valid cycle.
- rdy low: no state change, mem_wr forced 0, resp pulses stretched until rdy returns.

## Configuration
- MEM_ARB_LOAD_SIGNEXT_EN
  - Defined: a load with d_signed=1 sign-extends from bit 8N-1 to XLEN.
  - Undefined: d_signed is ignored and all loads are zero-extended; the store-load buffer extends externally.

## Test plan
- LW d_addr=0x100, RAM bytes 11 22 33 44:
  - mem_a is 0x100..0x103 in cycles 1–4.
  - d_resp_valid in cycle 6 with d_resp_data=0x44332211.
- if_valid and d_valid both high in IDLE, then held:
  - Data is granted first.
  - Fetch is granted next, even though d_valid is re-asserted.
- SB of 0x41 to 0x30000 with io_buffer_full high for 3 cycles:
  - mem_wr=0 for those cycles plus 1 more.
  - Then one write of 0x41; d_resp_valid follows.
- flush during cycle 2 of LW: no d_resp_valid; if_ready high next cycle. Flush during SW: all 4 bytes written, d_resp_valid pulses.
- LB of 0x80 with d_signed=1:
  - Macro defined: d_resp_data=0xFFFFFF80.
  - Macro undefined: d_resp_data=0x00000080.
- rdy low for 2 cycles mid-fetch: mem_a holds, fetch completes 2 cycles late with the correct word.

Source files
------------

// File: rtl/mem_byte_arbiter.sv
// Byte-serial RAM/IO arbiter for the fetch and load/store channels.
// Load sign extension is enabled by defining MEM_ARB_LOAD_SIGNEXT_EN.
module mem_byte_arbiter #(
    parameter int ADDR_W = 32,
    parameter int XLEN = 32,
    parameter int IF_BYTES = 4,
    parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(32'h30000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              io_buffer_full,
    input  logic [7:0]        mem_dout,
    output logic [7:0]        mem_din,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              flush,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_resp_valid,
    output logic [XLEN-1:0]   if_resp_data,
    input  logic              d_valid,
    output logic              d_ready,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_signed,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    output logic              d_resp_valid,
    output logic [XLEN-1:0]   d_resp_data
);

    localparam int NB = XLEN / 8;
    localparam int CW = $clog2(NB + 1);
    localparam int LW = (NB > 1) ? $clog2(NB) : 1;
    localparam int MAX_SZ = $clog2(NB);

    typedef enum logic [2:0] {
        IDLE,
        IF_RD,
        D_RD,
        D_WR,
        DRAIN
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     n_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   buf_q;
    logic              is_d_q;
    logic              last_d_q;
    logic              io_full_q;
    logic              prev_rd_q;
    logic [LW-1:0]     prev_lane_q;

    logic              ready;
    logic              can_acc;
    logic              grant_if;
    logic              grant_d;
    logic [CW-1:0]     d_n;
    logic [ADDR_W-1:0] cur_a;
    logic [LW-1:0]     lane;
    logic              in_io;
    logic              stall;
    logic              last;
    logic              sx_en;
    logic [XLEN-1:0]   cap_word;

    assign ready    = (state_q == IDLE) && rdy && !rst;
    assign if_ready = ready;
    assign d_ready  = ready;
    assign can_acc  = ready && !flush;
    // A fetch goes next whenever data had the previous grant.
    assign grant_if = can_acc && if_valid && (last_d_q || !d_valid);
    assign grant_d  = can_acc && d_valid && !grant_if;

    assign cur_a = addr_q + ADDR_W'(cnt_q);
    assign lane  = cnt_q[LW-1:0];
    assign in_io = (cur_a - IO_BASE) < ADDR_W'(8);
    assign stall = (state_q == D_WR) && in_io &&
                   (io_buffer_full || io_full_q);
    assign last  = cnt_q == (n_q - CW'(1));

    always_comb begin
        if (int'(d_size) > MAX_SZ) begin
            d_n = CW'(NB);
        end else begin
            d_n = CW'(1) << d_size;
        end
    end

`ifdef MEM_ARB_LOAD_SIGNEXT_EN
    logic sgn_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            sgn_q <= 1'b0;
        end else if (grant_d) begin
            sgn_q <= d_signed;
        end
    end
    assign sx_en = sgn_q;
`else
    logic unused_sgn;
    assign unused_sgn = d_signed;
    assign sx_en = 1'b0;
`endif

    function automatic logic [XLEN-1:0] extend(
        input logic [XLEN-1:0] w,
        input logic [CW-1:0]   n,
        input logic            sgn
    );
        logic [XLEN-1:0] r;
        logic            msb;
        r   = w;
        msb = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (CW'(i + 1) == n) msb = w[8*i+7];
        end
        for (int i = 0; i < NB; i++) begin
            if (CW'(i) >= n) r[8*i +: 8] = {8{sgn & msb}};
        end
        return r;
    endfunction

    // The RAM answers the address of the previous cycle, frozen or not.
    always_comb begin
        cap_word = buf_q;
        for (int i = 0; i < NB; i++) begin
            if (prev_rd_q && LW'(i) == prev_lane_q) begin
                cap_word[8*i +: 8] = mem_dout;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = d_we ? D_WR : D_RD;
                end else if (grant_if) begin
                    state_d = IF_RD;
                end
            end
            IF_RD, D_RD: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (last) begin
                    state_d = DRAIN;
                end
            end
            D_WR: begin
                if (!stall && last) state_d = IDLE;
            end
            DRAIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_a   = '0;
        mem_din = '0;
        mem_wr  = 1'b0;
        unique case (state_q)
            IF_RD, D_RD: mem_a = cur_a;
            D_WR: begin
                if (!stall) begin
                    mem_a  = cur_a;
                    mem_wr = rdy;
                    for (int i = 0; i < NB; i++) begin
                        if (LW'(i) == lane) mem_din = wdata_q[8*i +: 8];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            n_q           <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            buf_q         <= '0;
            is_d_q        <= 1'b0;
            last_d_q      <= 1'b0;
            io_full_q     <= 1'b0;
            prev_rd_q     <= 1'b0;
            prev_lane_q   <= '0;
            if_resp_valid <= 1'b0;
            if_resp_data  <= '0;
            d_resp_valid  <= 1'b0;
            d_resp_data   <= '0;
        end else begin
            prev_rd_q   <= (state_q == IF_RD) || (state_q == D_RD);
            prev_lane_q <= lane;
            buf_q       <= cap_word;
            if (rdy) begin
                state_q       <= state_d;
                io_full_q     <= io_buffer_full;
                if_resp_valid <= 1'b0;
                d_resp_valid  <= 1'b0;
                if (flush) last_d_q <= 1'b0;
                case (state_q)
                    IDLE: begin
                        if (grant_d || grant_if) begin
                            addr_q   <= grant_d ? d_addr : if_addr;
                            n_q      <= grant_d ? d_n : CW'(IF_BYTES);
                            cnt_q    <= '0;
                            buf_q    <= '0;
                            wdata_q  <= d_wdata;
                            is_d_q   <= grant_d;
                            last_d_q <= grant_d;
                        end
                    end
                    IF_RD, D_RD: cnt_q <= cnt_q + CW'(1);
                    D_WR: begin
                        if (!stall) begin
                            if (last) begin
                                d_resp_valid <= 1'b1;
                                d_resp_data  <= '0;
                            end else begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end
                    end
                    DRAIN: begin
                        if (!flush) begin
                            if (is_d_q) begin
                                d_resp_valid <= 1'b1;
                                d_resp_data  <= extend(cap_word, n_q, sx_en);
                            end else begin
                                if_resp_valid <= 1'b1;
                                if_resp_data  <= cap_word;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_byte_arbiter.sv
// Directed bench for mem_byte_arbiter with a byte RAM model.
module tb_mem_byte_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        io_buffer_full = 1'b0;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        flush = 1'b0;
    logic        if_valid = 1'b0;
    logic        if_ready;
    logic [31:0] if_addr = '0;
    logic        if_resp_valid;
    logic [31:0] if_resp_data;
    logic        d_valid = 1'b0;
    logic        d_ready;
    logic        d_we = 1'b0;
    logic [1:0]  d_size = '0;
    logic        d_signed = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_resp_valid;
    logic [31:0] d_resp_data;

    int nvec = 0;
    int nbad = 0;
    int nwr = 0;

    logic        ld_en = 1'b0;
    logic [15:0] ld_a = '0;
    logic [7:0]  ld_d = '0;
    logic [7:0]  ram [0:65535];

`ifdef MEM_ARB_LOAD_SIGNEXT_EN
    localparam logic [31:0] LB_EXP = 32'hFFFF_FF80;
`else
    localparam logic [31:0] LB_EXP = 32'h0000_0080;
`endif

    mem_byte_arbiter dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
        .io_buffer_full(io_buffer_full),
        .mem_dout(mem_dout),
        .mem_din(mem_din),
        .mem_a(mem_a),
        .mem_wr(mem_wr),
        .flush(flush),
        .if_valid(if_valid),
        .if_ready(if_ready),
        .if_addr(if_addr),
        .if_resp_valid(if_resp_valid),
        .if_resp_data(if_resp_data),
        .d_valid(d_valid),
        .d_ready(d_ready),
        .d_we(d_we),
        .d_size(d_size),
        .d_signed(d_signed),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_resp_valid(d_resp_valid),
        .d_resp_data(d_resp_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_dout <= ram[mem_a[15:0]];
        if (ld_en) ram[ld_a] <= ld_d;
        if (mem_wr) begin
            ram[mem_a[15:0]] <= mem_din;
            nwr <= nwr + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        ld_a = a;
        ld_d = d;
        ld_en = 1'b1;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    task automatic wait_resp(input bit is_d, inout int lat);
        while (!(is_d ? d_resp_valid : if_resp_valid) && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] sz,
                        input logic sg, output int lat);
        @(posedge clk);
        #1;
        d_valid = 1'b1;
        d_we = 1'b0;
        d_size = sz;
        d_signed = sg;
        d_addr = a;
        @(posedge clk);
        #1 d_valid = 1'b0;
        lat = 0;
        wait_resp(1'b1, lat);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int w0;
        int cnt;
        poke(16'h0100, 8'h11);
        poke(16'h0101, 8'h22);
        poke(16'h0102, 8'h33);
        poke(16'h0103, 8'h44);
        poke(16'h0180, 8'h80);
        poke(16'h0200, 8'h13);
        poke(16'h0201, 8'h05);
        poke(16'h0202, 8'h10);
        poke(16'h0203, 8'h00);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_if_ready", if_ready, 1);
        check("rst_d_ready", d_ready, 1);
        check("rst_mem_a", mem_a, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_d_resp", d_resp_valid, 0);
        check("rst_if_resp", if_resp_valid, 0);
        check("rst_d_data", d_resp_data, 0);

        // flush blocks accept, then data wins, then fetch wins
        @(posedge clk);
        #1;
        flush = 1'b1;
        if_valid = 1'b1;
        if_addr = 32'h200;
        d_valid = 1'b1;
        d_we = 1'b0;
        d_size = 2'd2;
        d_addr = 32'h100;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_no_acc_rdy", if_ready, 1);
        check("flush_no_acc_a", mem_a, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("arb_data_first", mem_a, 32'h100);
        lat = 1;
        wait_resp(1'b1, lat);
        check("arb_d_lat", lat, 6);
        check("arb_d_data", d_resp_data, 32'h4433_2211);
        @(posedge clk);
        #1;
        if_valid = 1'b0;
        d_valid = 1'b0;
        @(negedge clk);
        check("arb_fetch_next", mem_a, 32'h200);
        lat = 1;
        wait_resp(1'b0, lat);
        check("arb_if_lat", lat, 6);
        check("arb_if_data", if_resp_data, 32'h0010_0513);

        // LW cycle by cycle
        @(posedge clk);
        #1;
        d_valid = 1'b1;
        d_we = 1'b0;
        d_size = 2'd2;
        d_addr = 32'h100;
        @(posedge clk);
        #1 d_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k <= 4) check($sformatf("lw_a%0d", k), mem_a, 32'h100 + k - 1);
            check($sformatf("lw_wr%0d", k), mem_wr, 0);
            check($sformatf("lw_v%0d", k), d_resp_valid, (k == 6));
        end
        check("lw_data", d_resp_data, 32'h4433_2211);

        load(32'h180, 2'd0, 1'b1, lat);
        check("lb_lat", lat, 3);
        check("lb_signed", d_resp_data, LB_EXP);
        load(32'h100, 2'd1, 1'b0, lat);
        check("lh_lat", lat, 4);
        check("lh_data", d_resp_data, 32'h2211);
        load(32'h100, 2'd3, 1'b0, lat);
        check("clamp_lat", lat, 6);
        check("clamp_data", d_resp_data, 32'h4433_2211);

        // SB to IO with the buffer full for 3 cycles
        w0 = nwr;
        @(posedge clk);
        #1;
        d_valid = 1'b1;
        d_we = 1'b1;
        d_size = 2'd0;
        d_addr = 32'h30000;
        d_wdata = 32'h41;
        @(posedge clk);
        #1;
        d_valid = 1'b0;
        io_buffer_full = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("io_stall%0d", k), mem_wr, 0);
            @(posedge clk);
            #1;
        end
        io_buffer_full = 1'b0;
        @(negedge clk);
        check("io_stall4_wr", mem_wr, 0);
        check("io_stall4_a", mem_a, 0);
        @(negedge clk);
        check("io_wr", mem_wr, 1);
        check("io_wr_a", mem_a, 32'h30000);
        check("io_wr_din", mem_din, 8'h41);
        check("io_wr_noresp", d_resp_valid, 0);
        @(negedge clk);
        check("io_resp", d_resp_valid, 1);
        check("io_resp_data", d_resp_data, 0);
        check("io_nwr", nwr - w0, 1);

        // flush in cycle 2 of a load aborts it
        @(posedge clk);
        #1;
        d_valid = 1'b1;
        d_we = 1'b0;
        d_size = 2'd2;
        d_addr = 32'h100;
        @(posedge clk);
        #1 d_valid = 1'b0;
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("fl_ld_ready", if_ready, 1);
        cnt = d_resp_valid ? 1 : 0;
        repeat (6) begin
            @(negedge clk);
            if (d_resp_valid) cnt++;
        end
        check("fl_ld_noresp", cnt, 0);

        // flush during a store does not stop it
        w0 = nwr;
        @(posedge clk);
        #1;
        d_valid = 1'b1;
        d_we = 1'b1;
        d_size = 2'd2;
        d_addr = 32'h140;
        d_wdata = 32'hA1B2_C3D4;
        @(posedge clk);
        #1 d_valid = 1'b0;
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        lat = 2;
        wait_resp(1'b1, lat);
        check("fl_sw_lat", lat, 5);
        check("fl_sw_data", d_resp_data, 0);
        check("fl_sw_nwr", nwr - w0, 4);
        load(32'h140, 2'd2, 1'b0, lat);
        check("fl_sw_readback", d_resp_data, 32'hA1B2_C3D4);

        // rdy low for 2 cycles mid-fetch
        @(posedge clk);
        #1;
        if_valid = 1'b1;
        if_addr = 32'h200;
        @(posedge clk);
        #1 if_valid = 1'b0;
        @(negedge clk);
        check("rdy_a1", mem_a, 32'h200);
        @(posedge clk);
        #1 rdy = 1'b0;
        @(negedge clk);
        check("rdy_a2", mem_a, 32'h201);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rdy_a3", mem_a, 32'h201);
        check("rdy_not_ready", if_ready, 0);
        @(posedge clk);
        #1 rdy = 1'b1;
        lat = 3;
        wait_resp(1'b0, lat);
        check("rdy_lat", lat, 8);
        check("rdy_data", if_resp_data, 32'h0010_0513);

        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
